// File: rtl/pmp_csr_writer_if.sv
// CSR write channel between the M-mode CSR unit and the PMP register owner.
// The master issues a request and holds it until Ready; the slave reports completion
// (Done) and whether any PMP state changed (PMPFlush).
interface pmp_csr_writer_if #(
  parameter int XLEN = 64
);
  logic            CSRWriteReq;
  logic [11:0]     CSRWriteAdr;
  logic [XLEN-1:0] CSRWriteVal;
  logic            Ready;
  logic            Done;
  logic            PMPFlush;

  modport master (
    output CSRWriteReq, CSRWriteAdr, CSRWriteVal,
    input  Ready, Done, PMPFlush
  );

  modport slave (
    input  CSRWriteReq, CSRWriteAdr, CSRWriteVal,
    output Ready, Done, PMPFlush
  );
endinterface

// File: rtl/pmp_csr_writer.sv
// PMP configuration/address register owner. Applies one CSR write at a time through a
// small FSM, enforcing WARL masking, the reserved W=1/R=0 encoding, entry locks and the
// TOR lock on the preceding pmpaddr. Pulses PMPFlush when the write changed any state.
module pmp_csr_writer #(
  parameter int PMP_ENTRIES = 16,
  parameter int PA_BITS     = 56,
  parameter int XLEN        = 64
) (
  input  logic                                   clk,
  input  logic                                   reset,
  pmp_csr_writer_if.slave                        wr,
  input  logic [11:0]                            CSRReadAdr,
  output logic [XLEN-1:0]                        CSRReadVal,
  output logic [PMP_ENTRIES-1:0][7:0]            PMPCFG_ARRAY_REGW,
  output logic [PMP_ENTRIES-1:0][PA_BITS-3:0]    PMPADDR_ARRAY_REGW
);
  localparam int          CFGPER = XLEN / 8;
  localparam int          KW     = $clog2(CFGPER);
  localparam logic [7:0]  NENT   = 8'(PMP_ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_ADDR  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                               state_q, state_d;
  logic [11:0]                          adr_q, adr_d;
  logic [XLEN-1:0]                      val_q, val_d;
  logic [KW-1:0]                        k_q, k_d;
  logic                                 changed_q, changed_d;
  logic                                 ready_q, done_q, flush_q;
  logic [PMP_ENTRIES-1:0][7:0]          cfg_q, cfg_d;
  logic [PMP_ENTRIES-1:0][PA_BITS-3:0]  addr_q, addr_d;
  logic [7:0]                           e_s;
  logic [7:0]                           byte_s;
  logic                                 rsvd_s;
  logic [PMP_ENTRIES:0]                 tor_lock_s;

  // First entry covered by a pmpcfg CSR; odd CSRs on RV64 map nowhere.
  function automatic logic [7:0] cfg_base(input logic [11:0] adr);
    if (XLEN == 64) return {2'b00, adr[3:1], 3'b000};
    else            return {2'b00, adr[3:0], 2'b00};
  endfunction

  function automatic logic cfg_legal(input logic [11:0] adr);
    return (adr[11:4] == 8'h3A) && !((XLEN == 64) && adr[0]) && (cfg_base(adr) < NENT);
  endfunction

  function automatic logic [7:0] addr_index(input logic [11:0] adr);
    logic [11:0] off;
    off = adr - 12'h3B0;
    return off[7:0];
  endfunction

  function automatic logic addr_legal(input logic [11:0] adr);
    return (adr >= 12'h3B0) && (adr <= 12'h3EF) && (addr_index(adr) < NENT);
  endfunction

  assign wr.Ready           = ready_q;
  assign wr.Done            = done_q;
  assign wr.PMPFlush        = flush_q;
  assign PMPCFG_ARRAY_REGW  = cfg_q;
  assign PMPADDR_ARRAY_REGW = addr_q;

  // Entry i is TOR-locked by entry i+1 being locked in TOR mode; top slot never locks.
  always_comb begin
    tor_lock_s = '0;
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      tor_lock_s[i] = cfg_q[i][7] & (cfg_q[i][4:3] == 2'b01);
    end
  end

  // Next-state, write-application and change-detection logic.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    val_d     = val_q;
    k_d       = k_q;
    changed_d = changed_q;
    cfg_d     = cfg_q;
    addr_d    = addr_q;
    e_s       = 8'h00;
    byte_s    = 8'h00;
    for (int j = 0; j < CFGPER; j++) begin
      if (k_q == KW'(j)) byte_s = val_q[8*j +: 8];
      else               byte_s = byte_s;
    end
    byte_s[6:5] = 2'b00;
    rsvd_s      = byte_s[1] & ~byte_s[0];

    case (state_q)
      S_IDLE: begin
        if (wr.CSRWriteReq && ready_q) begin
          adr_d     = wr.CSRWriteAdr;
          val_d     = wr.CSRWriteVal;
          changed_d = 1'b0;
          k_d       = '0;
          if (cfg_legal(wr.CSRWriteAdr))       state_d = S_CFG;
          else if (addr_legal(wr.CSRWriteAdr)) state_d = S_ADDR;
          else                                 state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CFG: begin
        e_s = cfg_base(adr_q) + 8'(k_q);
        for (int i = 0; i < PMP_ENTRIES; i++) begin
          // Lock is judged on this entry's own pre-write value only.
          if ((e_s == 8'(i)) && !cfg_q[i][7] && !rsvd_s) begin
            cfg_d[i] = byte_s;
            if (byte_s != cfg_q[i]) changed_d = 1'b1;
            else                    changed_d = changed_d;
          end else begin
            cfg_d[i] = cfg_d[i];
          end
        end
        k_d = k_q + KW'(1);
        if (k_q == KW'(CFGPER - 1)) state_d = S_FLUSH;
        else                        state_d = S_CFG;
      end
      S_ADDR: begin
        e_s = addr_index(adr_q);
        for (int i = 0; i < PMP_ENTRIES; i++) begin
          if ((e_s == 8'(i)) && !cfg_q[i][7] && !tor_lock_s[i+1]) begin
            addr_d[i] = val_q[PA_BITS-3:0];
            if (val_q[PA_BITS-3:0] != addr_q[i]) changed_d = 1'b1;
            else                                 changed_d = changed_d;
          end else begin
            addr_d[i] = addr_d[i];
          end
        end
        state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Combinational readback; CSRs that map to no implemented entry read as zero.
  always_comb begin
    CSRReadVal = '0;
    if (cfg_legal(CSRReadAdr)) begin
      for (int j = 0; j < CFGPER; j++) begin
        for (int i = 0; i < PMP_ENTRIES; i++) begin
          if (int'(cfg_base(CSRReadAdr)) + j == i) CSRReadVal[8*j +: 8] = cfg_q[i];
          else                                     CSRReadVal = CSRReadVal;
        end
      end
    end else if (addr_legal(CSRReadAdr)) begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        if (addr_index(CSRReadAdr) == 8'(i)) CSRReadVal = XLEN'(addr_q[i]);
        else                                 CSRReadVal = CSRReadVal;
      end
    end else begin
      CSRReadVal = '0;
    end
  end

  // State, latched request, PMP registers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      adr_q     <= 12'h000;
      val_q     <= '0;
      k_q       <= '0;
      changed_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      flush_q   <= 1'b0;
      cfg_q     <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      val_q     <= val_d;
      k_q       <= k_d;
      changed_q <= changed_d;
      ready_q   <= (state_d == S_IDLE);
      done_q    <= (state_d == S_DONE);
      flush_q   <= (state_d == S_FLUSH) && changed_d;
      cfg_q     <= cfg_d;
      addr_q    <= addr_d;
    end
  end
endmodule

// File: tb/tb_pmp_csr_writer.sv
// Directed bench for pmp_csr_writer (16 entries, PA_BITS=56, XLEN=64).
module tb_pmp_csr_writer;
  logic                 clk;
  logic                 reset;
  logic [11:0]          rd_adr;
  logic [63:0]          rd_val;
  logic [15:0][7:0]     cfg_arr;
  logic [15:0][53:0]    addr_arr;
  int                   errors;
  int                   checks;
  int                   lat;
  logic                 fl;
  logic                 seen;

  pmp_csr_writer_if #(.XLEN(64)) wif ();

  pmp_csr_writer #(.PMP_ENTRIES(16), .PA_BITS(56), .XLEN(64)) dut (
    .clk                (clk),
    .reset              (reset),
    .wr                 (wif),
    .CSRReadAdr         (rd_adr),
    .CSRReadVal         (rd_val),
    .PMPCFG_ARRAY_REGW  (cfg_arr),
    .PMPADDR_ARRAY_REGW (addr_arr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one write, return Done latency (cycles after accept, 0 = timeout) and flush flag.
  task automatic do_write(input logic [11:0] a, input logic [63:0] v,
                          output int l, output logic f);
    @(negedge clk);
    wif.CSRWriteReq = 1'b1;
    wif.CSRWriteAdr = a;
    wif.CSRWriteVal = v;
    @(posedge clk);
    l = 0;
    f = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      wif.CSRWriteReq = 1'b0;
      if (wif.PMPFlush) f = 1'b1;
      if (wif.Done) begin
        l = c;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    rd_adr = 12'h000;
    wif.CSRWriteReq = 1'b0;
    wif.CSRWriteAdr = 12'h000;
    wif.CSRWriteVal = 64'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(wif.Ready), 64'd1);
    check("rst_done",  64'(wif.Done), 64'd0);
    check("rst_flush", 64'(wif.PMPFlush), 64'd0);
    check("rst_cfg",   64'(|cfg_arr), 64'd0);
    check("rst_addr",  64'(|addr_arr), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // pmpaddr3
    do_write(12'h3B3, 64'h0000_0000_8000_0000, lat, fl);
    check("a3_lat",   64'(lat), 64'd3);
    check("a3_flush", 64'(fl), 64'd1);
    check("a3_val",   64'(addr_arr[3]), 64'h8000_0000);
    rd_adr = 12'h3B3; #1;
    check("a3_rd",    rd_val, 64'h0000_0000_8000_0000);
    check("a3_ready", 64'(wif.Ready), 64'd1);

    // pmpcfg0 with a locked TOR entry 2
    do_write(12'h3A0, 64'h0000_0000_0F8F_1B09, lat, fl);
    check("c0_lat",   64'(lat), 64'd10);
    check("c0_flush", 64'(fl), 64'd1);
    check("c0_e0",    64'(cfg_arr[0]), 64'h09);
    check("c0_e1",    64'(cfg_arr[1]), 64'h1B);
    check("c0_e2",    64'(cfg_arr[2]), 64'h8F);
    check("c0_e3",    64'(cfg_arr[3]), 64'h0F);
    rd_adr = 12'h3A0; #1;
    check("c0_rd",    rd_val, 64'h0000_0000_0F8F_1B09);

    do_write(12'h3A0, 64'h0, lat, fl);
    check("c0z_flush", 64'(fl), 64'd1);
    check("c0z_e0",    64'(cfg_arr[0]), 64'h00);
    check("c0z_e2",    64'(cfg_arr[2]), 64'h8F);
    check("c0z_e3",    64'(cfg_arr[3]), 64'h00);

    // entry 2 TOR lock blocks pmpaddr1
    do_write(12'h3B1, 64'h5, lat, fl);
    check("a1_lock",  64'(addr_arr[1]), 64'h0);
    check("a1_flush", 64'(fl), 64'd0);

    // cfg[5]=0x88 then pmpaddr4 is TOR-locked
    do_write(12'h3A0, 64'h0000_8800_0000_0000, lat, fl);
    check("c5_val",   64'(cfg_arr[5]), 64'h88);
    check("c5_flush", 64'(fl), 64'd1);
    do_write(12'h3B4, 64'h1234, lat, fl);
    check("a4_lat",   64'(lat), 64'd3);
    check("a4_val",   64'(addr_arr[4]), 64'h0);
    check("a4_flush", 64'(fl), 64'd0);

    // reserved W=1,R=0 encoding, then WARL masking of bits 6:5
    do_write(12'h3A0, 64'h0062_0000_0000_0000, lat, fl);
    check("c6_rsvd",  64'(cfg_arr[6]), 64'h00);
    check("c6_rflush", 64'(fl), 64'd0);
    do_write(12'h3A0, 64'h0063_0000_0000_0000, lat, fl);
    check("c6_warl",  64'(cfg_arr[6]), 64'h03);
    check("c6_flush", 64'(fl), 64'd1);
    rd_adr = 12'h3A0; #1;
    check("c0_rd2",   rd_val, 64'h0003_8800_008F_0000);

    // pmpcfg2 covers entries 8..15
    do_write(12'h3A2, 64'h1, lat, fl);
    check("c8_val",   64'(cfg_arr[8]), 64'h01);
    rd_adr = 12'h3A2; #1;
    check("c2_rd",    rd_val, 64'h1);

    // upper write bits ignored
    do_write(12'h3B7, 64'hFFFF_FFFF_FFFF_FFFF, lat, fl);
    check("a7_val",   64'(addr_arr[7]), 64'h003F_FFFF_FFFF_FFFF);
    rd_adr = 12'h3B7; #1;
    check("a7_rd",    rd_val, 64'h003F_FFFF_FFFF_FFFF);

    // illegal: odd pmpcfg, pmpaddr beyond entries
    do_write(12'h3A1, 64'hFFFF_FFFF_FFFF_FFFF, lat, fl);
    check("c1_lat",   64'(lat), 64'd1);
    check("c1_flush", 64'(fl), 64'd0);
    rd_adr = 12'h3A1; #1;
    check("c1_rd",    rd_val, 64'h0);
    do_write(12'h3C4, 64'h1234, lat, fl);
    check("a20_lat",  64'(lat), 64'd1);
    check("a20_flush", 64'(fl), 64'd0);
    rd_adr = 12'h3C4; #1;
    check("a20_rd",   rd_val, 64'h0);
    check("ill_cfg9", 64'(cfg_arr[9]), 64'h00);

    // reset in the middle of a pmpcfg write (k=3)
    @(negedge clk);
    wif.CSRWriteReq = 1'b1;
    wif.CSRWriteAdr = 12'h3A2;
    wif.CSRWriteVal = 64'h0101_0101_0101_0101;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      wif.CSRWriteReq = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_ready", 64'(wif.Ready), 64'd1);
    check("mr_done",  64'(wif.Done), 64'd0);
    check("mr_cfg",   64'(|cfg_arr), 64'd0);
    check("mr_addr",  64'(|addr_arr), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (wif.Done || wif.PMPFlush || !wif.Ready) seen = 1'b1;
    end
    check("mr_quiet", 64'(seen), 64'd0);

    // lock cleared by reset: pmpaddr2 now writable
    do_write(12'h3B2, 64'h55, lat, fl);
    check("a2_lat",   64'(lat), 64'd3);
    check("a2_val",   64'(addr_arr[2]), 64'h55);
    check("a2_flush", 64'(fl), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
